// File: rtl/keypad_pkg.sv
// ============================================================================
// Module   : keypad_pkg
// Purpose  : Shared FSM state type, default timing constants and decode
//            helpers for the 4x4 keypad scanner.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    localparam int unsigned c_scan_cycles_default     = 1000;
    localparam int unsigned c_debounce_cycles_default = 20000;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESSED  = 2'd2,
        REL_DB   = 2'd3
    } state_t;

    // True when exactly one active-low column line is asserted.
    function automatic logic single_low(input logic [3:0] col);
        return ($countones(~col) == 1);
    endfunction

    function automatic logic [1:0] low_index(input logic [3:0] col);
        logic [1:0] idx;
        case (col)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_scanner_sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop synchronizer for the asynchronous keypad column lines;
//            resets to "no key" (all lines high).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_meta;
    logic [3:0] r_sync;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_meta <= 4'hF;
            r_sync <= 4'hF;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

`default_nettype wire

// File: rtl/keypad_scanner.sv
// ============================================================================
// Module   : keypad_scanner
// Purpose  : 4x4 matrix keypad scanner with press/release debouncing; reports
//            one key code with a valid level and a single-cycle press strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_CYCLES     = c_scan_cycles_default,
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_default
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_col,
    output logic [3:0] o_row,
    output logic [3:0] o_keypad,
    output logic       o_key_valid,
    output logic       o_key_pulse
);

    localparam int unsigned c_max_cycles = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES
                                                                           : DEBOUNCE_CYCLES;
    localparam int unsigned c_cnt_w      = ($clog2(c_max_cycles) < 1) ? 1 : $clog2(c_max_cycles);
    localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(SCAN_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_db_last    = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [3:0]         w_col_s;
    logic [1:0]         w_row_next;
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [1:0]         r_row_idx;
    logic [3:0]         r_row_drv;
    logic [3:0]         r_key_pat;
    logic [3:0]         r_keypad;
    logic               r_key_valid;
    logic               r_key_pulse;

    sync_2ff u_sync (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (i_col),
        .o_q   (w_col_s)
    );

    assign w_row_next = r_row_idx + 2'd1;

    // One shared counter times both the row dwell and the debounce windows;
    // it always restarts at zero on a state change, so it never wraps.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= SCAN;
            r_cnt       <= '0;
            r_row_idx   <= 2'd0;
            r_row_drv   <= 4'b1110;
            r_key_pat   <= 4'hF;
            r_keypad    <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_pulse <= 1'b0;
        end else begin
            r_key_pulse <= 1'b0;
            case (r_state)
                SCAN: begin
                    if (r_cnt == c_dwell_last) begin
                        r_cnt <= '0;
                        if (single_low(w_col_s)) begin
                            r_key_pat <= w_col_s;
                            r_state   <= DEBOUNCE;
                        end else begin
                            r_row_idx <= w_row_next;
                            r_row_drv <= row_drive(w_row_next);
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (w_col_s != r_key_pat) begin
                        r_state   <= SCAN;
                        r_cnt     <= '0;
                        r_row_idx <= w_row_next;
                        r_row_drv <= row_drive(w_row_next);
                    end else if (r_cnt == c_db_last) begin
                        r_state     <= PRESSED;
                        r_cnt       <= '0;
                        r_keypad    <= {r_row_idx, low_index(r_key_pat)};
                        r_key_valid <= 1'b1;
                        r_key_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    // Extra keys only add low bits; only an all-high read counts as release.
                    if (w_col_s == 4'hF) begin
                        r_state <= REL_DB;
                        r_cnt   <= '0;
                    end
                end
                REL_DB: begin
                    if (w_col_s != 4'hF) begin
                        r_state <= PRESSED;
                        r_cnt   <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_state     <= SCAN;
                        r_cnt       <= '0;
                        r_key_valid <= 1'b0;
                        r_row_idx   <= w_row_next;
                        r_row_drv   <= row_drive(w_row_next);
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= SCAN;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign o_row       = r_row_drv;
    assign o_keypad    = r_keypad;
    assign o_key_valid = r_key_valid;
    assign o_key_pulse = r_key_pulse;

endmodule

`default_nettype wire

// File: doc/keypad_scanner.md
KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_CYCLES, default 1000: clock cycles each row is driven before its columns are sampled.
REQ-002 Parameter DEBOUNCE_CYCLES, default 20000: consecutive stable cycles needed to accept a press or a release.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 i_clk  input  1  system clock, rising edge.
REQ-005 i_rst  input  1  asynchronous active-high reset.
REQ-006 i_col  input  4  keypad column sense, active-low (pulled up), asynchronous to i_clk.
REQ-007 o_row  output  4  keypad row drive, active-low, exactly one bit low at all times.
REQ-008 o_keypad  output  4  last accepted key code; feeds the LSU keypad input port.
REQ-009 o_key_valid  output  1  high while an accepted key is held.
REQ-010 o_key_pulse  output  1  single-cycle strobe on press acceptance.

Function
REQ-011 i_col SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value col_s.
REQ-012 FSM states SHALL be: SCAN, DEBOUNCE, PRESSED, REL_DB.
REQ-013 SCAN: row index r cycles 0->1->2->3->0; o_row = ~(1<<r); each row is held SCAN_CYCLES cycles; col_s is sampled on the last dwell cycle only.
REQ-014 SCAN sample with exactly one col_s bit low: capture r and column c; go to DEBOUNCE; clear the counter; hold o_row.
REQ-015 SCAN sample with zero or more than one col_s bit low: ignore it and advance to the next row, wrapping 3->0.
REQ-016 DEBOUNCE: counter increments each cycle col_s equals the captured pattern.
  - On any mismatch: return to SCAN at the next row.
  - When the counter reaches DEBOUNCE_CYCLES-1 on a match: go to PRESSED.
REQ-017 Entering PRESSED:
  - o_keypad <= {r[1:0], c[1:0]}, i.e. code = 4*row + col;
  - o_key_valid <= 1;
  - o_key_pulse = 1 for exactly that one cycle.
REQ-018 PRESSED: hold o_row; when col_s = 4'hF go to REL_DB with the counter cleared.
REQ-019 REL_DB: counter increments while col_s = 4'hF.
  - Any low bit: return to PRESSED with no new pulse.
  - Reaching DEBOUNCE_CYCLES-1: go to SCAN at the next row and set o_key_valid <= 0.
REQ-020 o_keypad SHALL hold the last accepted code after release until the next acceptance.
REQ-021 A second key pressed while in PRESSED SHALL be ignored; only one key is tracked.
REQ-022 The counter SHALL be $clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES)) bits, shared by dwell and debounce timing, and SHALL never wrap.
REQ-023 Press-to-pulse latency SHALL be 2 (sync) + remaining row dwell + DEBOUNCE_CYCLES cycles, all deterministic.

Reset
REQ-024 On i_rst, asynchronously:
  - state = SCAN, r = 0, o_row = 4'b1110;
  - o_keypad = 4'h0, o_key_valid = 0, o_key_pulse = 0;
  - counter = 0, synchronizer flops = 4'hF.
REQ-025 Reset asserted mid-DEBOUNCE or mid-PRESSED SHALL discard the pending key with no pulse; scanning restarts at row 0 one cycle after deassertion.

Structure
REQ-026 Package keypad_pkg SHALL hold the state enum (SCAN, DEBOUNCE, PRESSED, REL_DB) and the default SCAN_CYCLES/DEBOUNCE_CYCLES constants.
REQ-027 The synchronizer SHALL be sub-module sync_2ff (4 bits wide, async active-high reset, reset value 4'hF).

Verification (bench parameters: SCAN_CYCLES=4, DEBOUNCE_CYCLES=8)
REQ-028 Reset: assert i_rst mid-clock -> o_row=1110, o_keypad=0, o_key_valid=0, o_key_pulse=0 immediately; after release o_row walks 1110, 1101, 1011, 0111, 1110, each held 4 cycles.
REQ-029 Clean press: i_col=1101 whenever o_row=1011 -> o_keypad=4'h9, o_key_valid=1, o_key_pulse high exactly one cycle, o_row frozen at 1011.
REQ-030 Bounce: same key held 5 cycles, then released for 2 cycles, repeated -> no pulse, o_key_valid stays 0, scanning continues.
REQ-031 Multi-key: i_col=1001 on row 0 -> sample ignored, row advances, no pulse.
REQ-032 Release: from test REQ-029, drive i_col=1111.
  - After a 3-cycle release, bounce back to 1101 -> o_key_valid stays 1 and no second pulse.
  - After a full 8-cycle release -> o_key_valid=0, o_keypad stays 4'h9, scanning resumes at 0111.
REQ-033 Reset mid-PRESSED: i_rst pulse while o_key_valid=1 -> all outputs reset immediately; with the key still held, re-acceptance produces a fresh pulse.
